// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART packet decoder: start-of-frame default, error codes
// and FSM state encodings.
package uart_pkt_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] LEN     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] CSUM    = 2'd3;

endpackage

// File: rtl/uart_packet_decoder_if.sv
// Payload stream from the packet decoder to the processor side (valid/ready).
interface uart_packet_decoder_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/uart_byte_fetch.sv
// Read handshake against the controller RX FIFO: one RE pulse per byte, data taken the
// following cycle, so at most one byte every two clocks.
module uart_byte_fetch (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_empty_i,
    input  logic [7:0] rx_data_i,
    input  logic       stall_i,
    output logic       re_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    logic pending_q, pending_d;

    // No new read while one is outstanding; the outstanding one always completes.
    always_comb begin
        re_o      = !rx_empty_i && !pending_q && !stall_i;
        pending_d = re_o;
    end

    assign byte_o       = rx_data_i;
    assign byte_valid_o = pending_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/uart_packet_decoder.sv
// Frames RX FIFO bytes into SOF/LEN/payload/CSUM packets and streams the payload.
// Optional inter-byte timeout is enabled by defining PKT_TIMEOUT_EN.
module uart_packet_decoder
    import uart_pkt_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 64,
    parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT
`ifdef PKT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CLKS = 208320
`endif
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  rx_empty,
    input  logic [7:0]            receive_data,
    output logic                  RE,
    uart_packet_decoder_if.master out_if,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic [1:0]            err_code
);

    localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

    logic [1:0] state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       pkt_done_q, pkt_done_d;
    logic       pkt_err_q, pkt_err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       stall;

    assign stall = out_valid_q && !out_if.out_ready;

    uart_byte_fetch u_fetch (
        .clk_i        (CLOCK_50),
        .rst_ni       (rst_n),
        .rx_empty_i   (rx_empty),
        .rx_data_i    (receive_data),
        .stall_i      (stall),
        .re_o         (RE),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_byte_valid)
    );

`ifdef PKT_TIMEOUT_EN
    localparam int unsigned    TmoW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;

        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (rx_byte_valid) begin
            case (state_q)
                HUNT: begin
                    if (rx_byte == SOF_BYTE) state_d = LEN;
                end
                LEN: begin
                    sum_d = rx_byte;
                    if (rx_byte > MaxLenB) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = HUNT;
                    end else if (rx_byte == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        cnt_d   = rx_byte;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // The output slot is always free here: RE was gated on it.
                    out_data_d  = rx_byte;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == 8'd1);
                    sum_d       = sum_q + rx_byte;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = CSUM;
                end
                CSUM: begin
                    if (rx_byte == sum_q) begin
                        pkt_done_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end

`ifdef PKT_TIMEOUT_EN
        tmo_d = '0;
        if (!rx_byte_valid && state_q != HUNT) begin
            if (tmo_q == TmoLast) begin
                // Abort leaves any presented payload byte in place for delivery.
                pkt_err_d  = 1'b1;
                err_code_d = ERR_TMO;
                state_d    = HUNT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sum_q       <= 8'd0;
            cnt_q       <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef PKT_TIMEOUT_EN
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign pkt_done         = pkt_done_q;
    assign pkt_err          = pkt_err_q;
    assign err_code         = err_code_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Self-checking bench: FIFO model feeds directed and random frames; a stream parser
// predicts payload bytes and done/error events.
`timescale 1ns/1ps
module tb_uart_packet_decoder;

    localparam int MaxLen  = 64;
    localparam int TmoClks = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] receive_data = 8'd0;
    logic       RE, pkt_done, pkt_err;
    logic [1:0] err_code;

    uart_packet_decoder_if out_if ();

`ifdef PKT_TIMEOUT_EN
    uart_packet_decoder #(.MAX_LEN(MaxLen), .TIMEOUT_CLKS(TmoClks)) dut (
`else
    uart_packet_decoder #(.MAX_LEN(MaxLen)) dut (
`endif
        .CLOCK_50     (clk),
        .rst_n        (rst_n),
        .rx_empty     (rx_empty),
        .receive_data (receive_data),
        .RE           (RE),
        .out_if       (out_if),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .err_code     (err_code)
    );

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    logic [7:0] fifo[$];
    logic [7:0] chunk[$];
    logic [8:0] exp_data[$];  // {last, data}
    int         exp_ev[$];    // 0 done, else error code

    bit         stalled_prev = 1'b0;
    logic [8:0] prev_out = 9'd0;
    logic       re_prev = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RX FIFO: data appears the cycle after RE; empty flag tracks occupancy.
    always @(posedge clk) begin
        if (RE && fifo.size() > 0) receive_data <= fifo.pop_front();
        rx_empty <= (fifo.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_if.out_ready = 1'b1;
            1:       out_if.out_ready = ($urandom_range(0, 3) != 0);
            default: out_if.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_if.out_valid && out_if.out_ready) begin
                chk("out_expected", 32'(exp_data.size() > 0), 32'd1);
                if (exp_data.size() > 0)
                    chk("out_byte", 32'({out_if.out_last, out_if.out_data}),
                        32'(exp_data.pop_front()));
            end
            if (out_if.out_valid && !out_if.out_ready) begin
                chk("re_in_stall", 32'(RE), 32'd0);
                if (stalled_prev)
                    chk("hold_out", 32'({out_if.out_last, out_if.out_data}), 32'(prev_out));
            end
            stalled_prev = out_if.out_valid && !out_if.out_ready;
            prev_out     = {out_if.out_last, out_if.out_data};
            if (pkt_done || pkt_err) begin
                chk("evt_expected", 32'(exp_ev.size() > 0), 32'd1);
                if (exp_ev.size() > 0)
                    chk("evt_kind", (pkt_done && pkt_err) ? 32'd4 :
                        (pkt_err ? 32'(err_code) : 32'd0), 32'(exp_ev.pop_front()));
            end
            chk("re_when_empty", 32'(RE && rx_empty), 32'd0);
            chk("re_one_cycle", 32'(RE && re_prev), 32'd0);
            re_prev = RE;
        end
    end

    // Reference parse of a complete byte chunk; checksum covers LEN and payload.
    task automatic model_chunk();
        int i = 0;
        int len;
        logic [7:0] s;
        while (i < chunk.size()) begin
            if (chunk[i] != 8'hA5) begin
                i++;
                continue;
            end
            len = int'(chunk[i+1]);
            if (len > MaxLen) begin
                exp_ev.push_back(2);
                i += 2;
                continue;
            end
            s = chunk[i+1];
            for (int j = 0; j < len; j++) begin
                exp_data.push_back({(j == len - 1), chunk[i+2+j]});
                s += chunk[i+2+j];
            end
            exp_ev.push_back((chunk[i+2+len] == s) ? 0 : 1);
            i += len + 3;
        end
    endtask

    task automatic send_chunk();
        foreach (chunk[k]) fifo.push_back(chunk[k]);
        model_chunk();
        chunk.delete();
    endtask

    task automatic add_frame(input int kind, input int len);
        logic [7:0] s, b;
        chunk.push_back(8'hA5);
        if (kind == 2) begin
            chunk.push_back(8'($urandom_range(MaxLen + 1, 255)));
            return;
        end
        s = 8'(len);
        chunk.push_back(s);
        for (int j = 0; j < len; j++) begin
            b = 8'($urandom_range(0, 255));
            chunk.push_back(b);
            s += b;
        end
        chunk.push_back(kind == 1 ? s + 8'($urandom_range(1, 255)) : s);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo.size() > 0 || exp_data.size() > 0 || exp_ev.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < budget), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("rst_re", 32'(RE), 32'd0);
        chk("rst_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_last", 32'(out_if.out_last), 32'd0);
        chk("rst_data", 32'(out_if.out_data), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        chk("rst_err", 32'(pkt_err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chunk = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_chunk();
        drain(200);
        chunk = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h80};
        send_chunk();
        drain(200);
        chunk = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        send_chunk();
        drain(200);
        chunk = '{8'hA5, 8'h41, 8'hA5, 8'h01, 8'h05, 8'h06};
        send_chunk();
        drain(200);

        // Backpressure: first payload byte parks on the output, the rest stay queued.
        ready_mode = 2;
        @(negedge clk);
        chunk = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        send_chunk();
        n = 0;
        while (!out_if.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(out_if.out_valid), 32'd1);
        repeat (50) @(negedge clk);
        chk("bp_fifo_kept", 32'(fifo.size()), 32'd4);
        chk("bp_data", 32'(out_if.out_data), 32'h01);
        ready_mode = 0;
        drain(200);

        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                b = 8'($urandom_range(0, 255));
                chunk.push_back(b == 8'hA5 ? 8'h5A : b);
            end
            n = $urandom_range(0, 9);
            add_frame(n == 0 ? 2 : (n < 3 ? 1 : 0),
                      ($urandom_range(0, 7) == 0) ? MaxLen : $urandom_range(0, 12));
            send_chunk();
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        drain(20000);
        ready_mode = 0;

`ifdef PKT_TIMEOUT_EN
        @(negedge clk);
        chunk = '{8'hA5, 8'h02, 8'h11};
        foreach (chunk[k]) fifo.push_back(chunk[k]);
        chunk.delete();
        exp_data.push_back({1'b0, 8'h11});
        exp_ev.push_back(3);
        n = 0;
        while (!out_if.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!pkt_err && n < 3 * TmoClks) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TmoClks));
        drain(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
